adc_capture: RTL and testbench
==============================

ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 16, capture buffer depth in 256-bit words (16 x 16-bit samples each).
REQ-002 SHALL have parameter CFG_BITS, default 32, width of each serially loaded config register.
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port gpio_ctrl  in  16  serial config/readback lines; bit indices from rfsoc_config.
REQ-006 SHALL have port select_in  in  1  gates all gpio_ctrl edge actions.
REQ-007 SHALL have port s_axis_tdata  in  256  ADC sample word.
REQ-008 SHALL have port s_axis_tvalid  in  1  sample word valid.
REQ-009 SHALL have port s_axis_tready  out  1  constant 1; the ADC stream is never stalled.
REQ-010 SHALL have port trigger_in  in  1  capture start, 1-cycle pulse.
REQ-011 SHALL have port sdata_out  out  1  serial readback data bit.
REQ-012 SHALL have port busy  out  1  high in DELAY or CAPTURE.
REQ-013 SHALL have port capture_done  out  1  high in DONE.

Function
REQ-014 SHALL pass gpio_ctrl and select_in through 2-flop synchronizers; an action fires on the synchronized rising edge of a gpio_ctrl clock bit while synchronized select_in=1.
REQ-015 SHALL hold cap_count and pre_delay as CFG_BITS shift registers: on each cap_count_clk / cap_delay_clk edge, shift right one bit and load synchronized gpio_ctrl[sdata] into the MSB, so an LSB-first stream of CFG_BITS bits ends with bit 0 at position 0.
REQ-016 SHALL implement states IDLE, DELAY, CAPTURE, DONE.
- IDLE->DELAY on trigger_in.
- Pre_delay=0 goes IDLE->CAPTURE directly.
REQ-017 DELAY SHALL count pre_delay clk cycles, then enter CAPTURE.
REQ-018 CAPTURE SHALL write each beat with s_axis_tvalid=1 to buffer[wr_ptr] and increment wr_ptr; it SHALL enter DONE in the cycle the eff_count-th word is written.
REQ-019 Beats outside CAPTURE SHALL be discarded.
REQ-020 eff_count SHALL be min(cap_count, DEPTH); eff_count=0 goes from trigger straight to DONE with no writes.
REQ-021 trigger_in in DELAY or CAPTURE SHALL be ignored; trigger_in in DONE SHALL re-arm (clear wr_ptr and rd_ptr, go to DELAY/CAPTURE per REQ-016).
REQ-022 Readback, DONE only: sdata_out = bit (rd_ptr mod 256) of buffer[rd_ptr/256], combinationally from registered rd_ptr; each readback_clk edge increments rd_ptr.
REQ-023 rd_ptr SHALL wrap to 0 after eff_count*256-1.
REQ-024 sdata_out SHALL be 0 outside DONE or when eff_count=0; readback_clk edges outside DONE are ignored.
REQ-025 Config edges during DELAY/CAPTURE SHALL update the shift registers, but eff_count and pre_delay SHALL be latched at trigger and be unaffected.

Reset
REQ-026 rst SHALL force IDLE and clear wr_ptr, rd_ptr, the delay counter, cap_count, pre_delay, synchronizers and edge detectors.
- Outputs after reset: busy=0, capture_done=0, sdata_out=0.
REQ-027 rst mid-capture SHALL abort with no DONE; buffer contents are not cleared and are don't-care.

Configuration
REQ-028 With ADC_CAPTURE_TIMESTAMP_EN defined:
- A free-running 32-bit cycle counter (cleared by rst, wraps) SHALL be latched on each accepted trigger.
- Readback SHALL append those 32 bits, LSB first, after the buffer bits; the wrap point becomes eff_count*256+31.
- With eff_count=0, readback SHALL serve only those 32 bits.
REQ-029 Without ADC_CAPTURE_TIMESTAMP_EN, there SHALL be no counter, and readback SHALL be exactly per REQ-022..024.

Structure
REQ-030 Package rfsoc_config SHALL hold:
- Existing index sdata.
- New indices cap_count_clk, cap_delay_clk, readback_clk, unused by other blocks.
- The capture state enum.
- Constants SAMPLES_PER_WORD=16, SAMPLE_BITS=16.
REQ-031 Sub-module serial_cfg_reg SHALL implement one synchronized, edge-detected, select-gated CFG_BITS shift register; it is instantiated twice.

Verification
REQ-032 Load cap_count=3, pre_delay=2; trigger; tvalid every cycle with words 0x..A, 0x..B, 0x..C, 0x..D -> busy for 2+3 cycles, buffer holds A,B,C, capture_done=1.
REQ-033 Readback 768 edges after REQ-032 -> bit stream equals A,B,C LSB-first; the 769th bit equals A bit 0 (wrap).
REQ-034 cap_count=40, DEPTH=16 -> exactly 16 words captured, wrap at 4096 bits.
REQ-035 cap_count=0; trigger -> DONE next cycle, sdata_out=0, no writes.
REQ-036 Gapped tvalid (1 of 3 cycles) plus a second trigger mid-CAPTURE -> only valid beats stored, second trigger ignored.
REQ-037 rst asserted mid-CAPTURE -> IDLE next cycle, all outputs 0.
- With ADC_CAPTURE_TIMESTAMP_EN, a trigger at cycle 1000 after reset -> trailing 32 readback bits = 1000 (REQ-028 latency fixed by bench).

Source files
------------

// File: rtl/adc_capture_pkg.sv
// rfsoc_config: GPIO line indices, capture FSM states and sample geometry
// shared by the ADC capture block.
package rfsoc_config;

  // Line indices into gpio_ctrl. sdata is the existing serial data line.
  // The other three lines are used only by adc_capture.
  localparam int unsigned sdata         = 0;
  localparam int unsigned cap_count_clk = 1;
  localparam int unsigned cap_delay_clk = 2;
  localparam int unsigned readback_clk  = 3;

  localparam int unsigned SAMPLES_PER_WORD = 16;
  localparam int unsigned SAMPLE_BITS      = 16;
  localparam int unsigned WORD_BITS        = SAMPLES_PER_WORD * SAMPLE_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

endpackage

// File: rtl/serial_cfg_reg.sv
// serial_cfg_reg: one LSB-first serially loaded configuration register.
// The clock, data and select lines are each passed through a 2-flop
// synchronizer. A shift happens on the synchronized rising edge of the clock
// line, and only while the synchronized select line is high.
module serial_cfg_reg #(
  parameter int unsigned CFG_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_line_i,
  input  logic                data_line_i,
  input  logic                select_i,
  output logic [CFG_BITS-1:0] q_o
);

  logic [1:0]          clk_sync_q;
  logic [1:0]          dat_sync_q;
  logic [1:0]          sel_sync_q;
  logic                clk_prev_q;
  logic [CFG_BITS-1:0] shift_q;
  logic                fire;

  assign fire = clk_sync_q[1] & ~clk_prev_q & sel_sync_q[1];
  assign q_o  = shift_q;

  // Synchronizers and edge detector; shift the new bit in at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      sel_sync_q <= '0;
      clk_prev_q <= 1'b0;
      shift_q    <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], clk_line_i};
      dat_sync_q <= {dat_sync_q[0], data_line_i};
      sel_sync_q <= {sel_sync_q[0], select_i};
      clk_prev_q <= clk_sync_q[1];
      if (fire) begin
        shift_q <= {dat_sync_q[1], shift_q[CFG_BITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/adc_capture.sv
// adc_capture: captures a triggered burst of 256-bit ADC words into a small
// buffer and serves it back one bit per readback_clk edge on sdata_out.
// Optional macro ADC_CAPTURE_TIMESTAMP_EN adds a trigger timestamp. The
// timestamp is 32 bits and is appended to the readback stream.
module adc_capture
  import rfsoc_config::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CFG_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          gpio_ctrl,
  input  logic                 select_in,
  input  logic [WORD_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 trigger_in,
  output logic                 sdata_out,
  output logic                 busy,
  output logic                 capture_done
);

`ifdef ADC_CAPTURE_TIMESTAMP_EN
  localparam int unsigned TS_BITS = 32;
`else
  localparam int unsigned TS_BITS = 0;
`endif
  localparam int unsigned WPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW  = $clog2(DEPTH + 1);
  localparam int unsigned RDW = $clog2(DEPTH * WORD_BITS + TS_BITS + 1);

  logic [CFG_BITS-1:0] cap_cfg, pd_cfg;
  logic                gpio_unused;

  cap_state_e          state_q, state_d;
  logic [EW-1:0]       wr_q, wr_d, eff_q, eff_d, eff_now;
  logic [RDW-1:0]      rd_q, rd_d, rd_last, buf_bits;
  logic [CFG_BITS-1:0] dly_q, dly_d, pd_q, pd_d;
  logic                busy_q, done_q;
  logic                arm, rd_fire;

  logic [1:0]          rb_sync_q, sel_sync_q;
  logic                rb_prev_q, rb_rise;

  logic [WORD_BITS-1:0] mem_q [DEPTH];

  assign s_axis_tready = 1'b1;
  assign busy          = busy_q;
  assign capture_done  = done_q;
  assign gpio_unused   = ^gpio_ctrl;

  serial_cfg_reg #(.CFG_BITS(CFG_BITS)) u_cap_count (
    .clk         (clk),
    .rst         (rst),
    .clk_line_i  (gpio_ctrl[cap_count_clk]),
    .data_line_i (gpio_ctrl[sdata]),
    .select_i    (select_in),
    .q_o         (cap_cfg)
  );

  serial_cfg_reg #(.CFG_BITS(CFG_BITS)) u_pre_delay (
    .clk         (clk),
    .rst         (rst),
    .clk_line_i  (gpio_ctrl[cap_delay_clk]),
    .data_line_i (gpio_ctrl[sdata]),
    .select_i    (select_in),
    .q_o         (pd_cfg)
  );

  // Synchronize readback clock and select, detect the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_sync_q  <= '0;
      sel_sync_q <= '0;
      rb_prev_q  <= 1'b0;
    end else begin
      rb_sync_q  <= {rb_sync_q[0], gpio_ctrl[readback_clk]};
      sel_sync_q <= {sel_sync_q[0], select_in};
      rb_prev_q  <= rb_sync_q[1];
    end
  end

  assign rb_rise  = rb_sync_q[1] & ~rb_prev_q & sel_sync_q[1];
  assign eff_now  = (cap_cfg >= CFG_BITS'(DEPTH)) ? EW'(DEPTH) : cap_cfg[EW-1:0];
  assign arm      = trigger_in && (state_q == ST_IDLE || state_q == ST_DONE);
  assign buf_bits = RDW'({eff_q, 8'h00});

`ifdef ADC_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_q;

  assign rd_last = buf_bits + RDW'(31);
  assign rd_fire = rb_rise && (state_q == ST_DONE);

  // Free-running cycle counter, sampled on every accepted trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (arm) begin
        ts_q <= ts_cnt_q;
      end
    end
  end

  // The buffer region always ends on a multiple of 256 bits, so the
  // timestamp bit index is simply the low five bits of rd_q.
  always_comb begin
    sdata_out = 1'b0;
    if (state_q == ST_DONE) begin
      if (rd_q < buf_bits) begin
        sdata_out = mem_q[rd_q[8 +: WPW]][rd_q[7:0]];
      end else begin
        sdata_out = ts_q[rd_q[4:0]];
      end
    end
  end
`else
  assign rd_last = buf_bits - RDW'(1);
  assign rd_fire = rb_rise && (state_q == ST_DONE) && (eff_q != '0);

  // Bit rd_q of the captured stream, zero unless holding a non-empty capture.
  always_comb begin
    sdata_out = 1'b0;
    if (state_q == ST_DONE && eff_q != '0) begin
      sdata_out = mem_q[rd_q[8 +: WPW]][rd_q[7:0]];
    end
  end
`endif

  // Capture FSM next-state, pointer and delay-counter logic.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    dly_d   = dly_q;
    eff_d   = eff_q;
    pd_d    = pd_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_DELAY: begin
        if (dly_q == pd_q - CFG_BITS'(1)) begin
          state_d = ST_CAPTURE;
        end else begin
          dly_d = dly_q + CFG_BITS'(1);
        end
      end
      ST_CAPTURE: begin
        if (s_axis_tvalid) begin
          wr_d = wr_q + EW'(1);
          if (wr_q + EW'(1) == eff_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (rd_fire) begin
          rd_d = (rd_q == rd_last) ? '0 : rd_q + RDW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A trigger in IDLE or DONE re-arms and takes precedence over readback.
    if (arm) begin
      wr_d  = '0;
      rd_d  = '0;
      dly_d = '0;
      eff_d = eff_now;
      pd_d  = pd_cfg;
      if (eff_now == '0) begin
        state_d = ST_DONE;
      end else if (pd_cfg == '0) begin
        state_d = ST_CAPTURE;
      end else begin
        state_d = ST_DELAY;
      end
    end
  end

  // State registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      dly_q   <= '0;
      eff_q   <= '0;
      pd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      dly_q   <= dly_d;
      eff_q   <= eff_d;
      pd_q    <= pd_d;
      busy_q  <= (state_d == ST_DELAY) || (state_d == ST_CAPTURE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Capture buffer; contents survive reset and are only meaningful in DONE.
  always_ff @(posedge clk) begin
    if (state_q == ST_CAPTURE && s_axis_tvalid) begin
      mem_q[wr_q[WPW-1:0]] <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// Testbench for adc_capture. It is table-driven over capture scenarios.
// A scoreboard queue holds the words expected back on serial readback.
// The trailing timestamp check runs only with ADC_CAPTURE_TIMESTAMP_EN.
module tb_adc_capture;
  import rfsoc_config::*;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned CFG_BITS = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  gpio_ctrl;
  logic         select_in;
  logic [255:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         trigger_in;
  logic         sdata_out;
  logic         busy;
  logic         capture_done;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [255:0] exp_q[$];

  adc_capture #(.DEPTH(DEPTH), .CFG_BITS(CFG_BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .gpio_ctrl     (gpio_ctrl),
    .select_in     (select_in),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .trigger_in    (trigger_in),
    .sdata_out     (sdata_out),
    .busy          (busy),
    .capture_done  (capture_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cap;
    int unsigned pd;
    int unsigned per;
    int unsigned trig2;
    int unsigned exp_words;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load_cfg(input int unsigned clk_idx, input logic [31:0] val);
    for (int i = 0; i < 32; i++) begin
      gpio_ctrl[sdata] = val[i];
      tick();
      gpio_ctrl[clk_idx] = 1'b1;
      repeat (3) tick();
      gpio_ctrl[clk_idx] = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic rb_pulse();
    gpio_ctrl[readback_clk] = 1'b1;
    repeat (3) tick();
    gpio_ctrl[readback_clk] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic read_word(output logic [255:0] w);
    for (int b = 0; b < 256; b++) begin
      w[b] = sdata_out;
      rb_pulse();
    end
  endtask

  task automatic run_vec(input int vi);
    int unsigned  cnt, jlast, busy_cnt, j;
    logic         valid;
    logic [255:0] word, got, first;
    load_cfg(cap_count_clk, vecs[vi].cap);
    load_cfg(cap_delay_clk, vecs[vi].pd);
    exp_q.delete();
    cnt = 0; jlast = 0; busy_cnt = 0; j = 0;
    trigger_in    = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();
    trigger_in = 1'b0;
    // Beat j is sampled at the j-th edge after the trigger edge. Writing
    // starts at beat pd+1.
    while (!capture_done && j < 300) begin
      busy_cnt += busy;
      j++;
      valid = (j % vecs[vi].per) == 0;
      for (int k = 0; k < 8; k++) word[k*32 +: 32] = $urandom;
      s_axis_tvalid = valid;
      s_axis_tdata  = word;
      if (valid && j > vecs[vi].pd && cnt < vecs[vi].exp_words) begin
        exp_q.push_back(word);
        cnt++;
        if (cnt == vecs[vi].exp_words) jlast = j;
      end
      trigger_in = (vecs[vi].trig2 != 0) && (j == vecs[vi].trig2);
      tick();
      trigger_in = 1'b0;
    end
    check($sformatf("v%0d_done", vi), capture_done, 1'b1);
    check($sformatf("v%0d_busy_cycles", vi), busy_cnt, jlast);
    check($sformatf("v%0d_busy_in_done", vi), busy, 1'b0);
    // Beats after DONE must not reach the buffer.
    for (int k = 0; k < 3; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {8{$urandom}};
      tick();
    end
    s_axis_tvalid = 1'b0;
    if (vecs[vi].exp_words == 0) begin
      check($sformatf("v%0d_sdata_empty", vi), sdata_out, 1'b0);
      rb_pulse();
      check($sformatf("v%0d_sdata_empty_after_edge", vi), sdata_out, 1'b0);
    end else begin
      first = exp_q[0];
      for (int w = 0; w < int'(vecs[vi].exp_words); w++) begin
        read_word(got);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL v%0d_scoreboard_empty actual=empty required=word", vi);
        end else begin
          check($sformatf("v%0d_word%0d", vi, w), got, exp_q.pop_front());
        end
      end
      check($sformatf("v%0d_wrap_bit", vi), sdata_out, first[0]);
    end
  endtask

  initial begin
    logic [255:0] got;
    vecs[0] = '{cap: 3,  pd: 2, per: 1, trig2: 0, exp_words: 3};
    vecs[1] = '{cap: 40, pd: 0, per: 1, trig2: 0, exp_words: 16};
    vecs[2] = '{cap: 0,  pd: 5, per: 1, trig2: 0, exp_words: 0};
    vecs[3] = '{cap: 4,  pd: 1, per: 3, trig2: 4, exp_words: 4};
    vecs[4] = '{cap: 2,  pd: 3, per: 2, trig2: 2, exp_words: 2};

    rst = 1'b1; gpio_ctrl = '0; select_in = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; trigger_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_busy", busy, 1'b0);
    check("reset_done", capture_done, 1'b0);
    check("reset_sdata", sdata_out, 1'b0);
    check("tready", s_axis_tready, 1'b1);
    rb_pulse();
    check("idle_sdata_after_rb", sdata_out, 1'b0);

    for (int v = 0; v < 5; v++) run_vec(v);

    // Reset while capturing aborts without ever showing DONE.
    load_cfg(cap_count_clk, 8);
    load_cfg(cap_delay_clk, 0);
    trigger_in = 1'b1;
    tick();
    trigger_in    = 1'b0;
    s_axis_tvalid = 1'b1;
    repeat (3) tick();
    check("midcap_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", capture_done, 1'b0);
    check("rst_sdata", sdata_out, 1'b0);
    rst = 1'b0;
    repeat (10) tick();
    s_axis_tvalid = 1'b0;
    check("post_rst_done", capture_done, 1'b0);
    check("post_rst_busy", busy, 1'b0);

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    // After reset cap_count is 0, so readback serves only the timestamp.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (1000) tick();
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    check("ts_done", capture_done, 1'b1);
    got = '0;
    for (int b = 0; b < 32; b++) begin
      got[b] = sdata_out;
      rb_pulse();
    end
    check("ts_value", got, 256'd1000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
